// File: rtl/brisc_pkg.sv
// Shared core types: memory port request/response and memory-port arbiter enums.
package brisc_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef struct packed {
    logic                 valid;
    logic                 rw;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic                 valid;
    logic [DataWidth-1:0] data;
  } mem_resp_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;

  typedef enum logic {OWN_I, OWN_D} arb_owner_e;

  // The dcache wins unless the icache is waiting and the dcache streak is exhausted.
  function automatic logic dcache_wins_arb(input logic ivalid, input logic dvalid,
                                           input logic streak_at_max);
    return dvalid && !(ivalid && streak_at_max);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable up-counter for the arbiter's WAIT state; flags expiry at TIMEOUT_CYCLES-1.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic [CntWidth-1:0] load_value,
  input  logic                enable,
  output logic                expired
);

  logic [CntWidth-1:0] count_q;

  // Counter register: clear beats load beats increment; holds once expired.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry decode.
  always_comb begin
    expired = (count_q == CntWidth'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory-port arbiter between icache and dcache with
// dcache priority, bounded icache starvation, timeout and spurious-response detection.
module mem_port_arbiter
  import brisc_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic      clk,
  input  logic      reset,
  input  mem_req_t  ireq_in,
  input  mem_req_t  dreq_in,
  input  mem_resp_t mem_resp_in,
  output mem_req_t  mem_req_out,
  output logic      igrant_out,
  output logic      dgrant_out,
  output logic      iresp_valid_out,
  output logic      dresp_valid_out,
  output logic      busy_out,
  output logic      timeout_err_out,
  output logic      spurious_err_out
);

  localparam int unsigned StreakWidth = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;

  arb_state_e             state_q, state_d;
  arb_owner_e             owner_q, owner_d;
  mem_req_t               req_q, req_d;
  logic [StreakWidth-1:0] streak_q, streak_d;
  logic                   igrant_q, igrant_d;
  logic                   dgrant_q, dgrant_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   spurious_err_q, spurious_err_d;

  logic streak_at_max;
  logic dcache_wins;
  logic resp_hit;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  // Response data is consumed by the caches directly, not by the arbiter.
  logic unused_resp_data;
  assign unused_resp_data = ^mem_resp_in.data;

  // Timer runs only in WAIT, so it is already zero on WAIT entry.
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .load      (1'b0),
    .load_value('0),
    .enable    (timer_enable),
    .expired   (timer_expired)
  );

  // State, latched request, streak, grant and sticky-error registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ARB_IDLE;
      owner_q        <= OWN_I;
      req_q          <= '0;
      streak_q       <= '0;
      igrant_q       <= 1'b0;
      dgrant_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      req_q          <= req_d;
      streak_q       <= streak_d;
      igrant_q       <= igrant_d;
      dgrant_q       <= dgrant_d;
      timeout_err_q  <= timeout_err_d;
      spurious_err_q <= spurious_err_d;
    end
  end

  // Next-state: arbitration in IDLE, one ISSUE cycle, WAIT until response or timeout.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    req_d          = req_q;
    streak_d       = streak_q;
    igrant_d       = igrant_q;
    dgrant_d       = dgrant_q;
    timeout_err_d  = timeout_err_q;
    spurious_err_d = spurious_err_q;
    dcache_wins    = 1'b0;
    streak_at_max  = (streak_q == StreakWidth'(MAX_DSTREAK));
    resp_hit       = (state_q == ARB_WAIT) && mem_resp_in.valid;
    timer_clear    = (state_q != ARB_WAIT);
    timer_enable   = (state_q == ARB_WAIT);

    unique case (state_q)
      ARB_IDLE: begin
        if (ireq_in.valid || dreq_in.valid) begin
          dcache_wins = dcache_wins_arb(ireq_in.valid, dreq_in.valid, streak_at_max);
          owner_d     = dcache_wins ? OWN_D : OWN_I;
          req_d       = dcache_wins ? dreq_in : ireq_in;
          req_d.valid = 1'b1;
          igrant_d    = !dcache_wins;
          dgrant_d    = dcache_wins;
          // Streak only grows while the icache is actually being passed over.
          if (dcache_wins && ireq_in.valid) begin
            streak_d = streak_at_max ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A response in the expiry cycle still wins over the timeout.
        if (mem_resp_in.valid) begin
          igrant_d = 1'b0;
          dgrant_d = 1'b0;
          state_d  = ARB_IDLE;
        end else if (timer_expired) begin
          timeout_err_d = 1'b1;
          igrant_d      = 1'b0;
          dgrant_d      = 1'b0;
          state_d       = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (mem_resp_in.valid && (state_q != ARB_WAIT)) begin
      spurious_err_d = 1'b1;
    end
  end

  // Outputs: request valid only in ISSUE, response pulses routed to the owner.
  always_comb begin
    mem_req_out       = req_q;
    mem_req_out.valid = req_q.valid && (state_q == ARB_ISSUE);
    igrant_out        = igrant_q;
    dgrant_out        = dgrant_q;
    iresp_valid_out   = resp_hit && (owner_q == OWN_I);
    dresp_valid_out   = resp_hit && (owner_q == OWN_D);
    busy_out          = (state_q != ARB_IDLE);
    timeout_err_out   = timeout_err_q;
    spurious_err_out  = spurious_err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected issues and
// responses; a monitor pops and compares whenever the DUT issues or pulses a response.
module tb_mem_port_arbiter;
  import brisc_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  mem_req_t  ireq, dreq, mem_req;
  mem_resp_t mem_resp;
  logic      igrant, dgrant, iresp, dresp, busy, terr, serr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        own_d;
    logic [31:0] addr;
  } iss_t;

  iss_t exp_iss[$];
  logic exp_resp[$];

  int lat = -1;       // memory latency in cycles after ISSUE; negative = never respond
  int spur_cnt = 0;   // bumped by the main thread to request one spurious response

  localparam logic [31:0] IAddr = 32'h100;
  localparam logic [31:0] DAddr = 32'h200;

  mem_port_arbiter #(
    .MAX_DSTREAK   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ireq_in         (ireq),
    .dreq_in         (dreq),
    .mem_resp_in     (mem_resp),
    .mem_req_out     (mem_req),
    .igrant_out      (igrant),
    .dgrant_out      (dgrant),
    .iresp_valid_out (iresp),
    .dresp_valid_out (dresp),
    .busy_out        (busy),
    .timeout_err_out (terr),
    .spurious_err_out(serr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sel: 0 issue, 1 iresp, 2 dresp, 3 any resp. Bounded by budget cycles.
  task automatic wait_for(input int sel, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((sel == 0 && mem_req.valid) || (sel == 1 && iresp) || (sel == 2 && dresp) ||
          (sel == 3 && (iresp || dresp))) break;
    end
    if (k == budget) begin
      checks++;
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic push_txn(input logic own_d, input logic [31:0] addr, input logic with_resp);
    iss_t e;
    e.own_d = own_d;
    e.addr  = addr;
    exp_iss.push_back(e);
    if (with_resp) exp_resp.push_back(own_d);
  endtask

  // Memory model: responds lat cycles after ISSUE; also injects requested spurious responses.
  initial begin
    int cnt = 0;
    int spur_seen = 0;
    mem_resp = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp.valid = 1'b0;
      if (spur_seen != spur_cnt) begin
        mem_resp.valid = 1'b1;
        spur_seen = spur_cnt;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_resp.valid = 1'b1;
          mem_resp.data  = $urandom;
        end
      end
      if (mem_req.valid && lat > 0) cnt = lat;
    end
  end

  // Monitor: compares every issue and response pulse against the scoreboard queues.
  initial begin
    iss_t e;
    logic r;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_req.valid) begin
          if (exp_iss.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: addr %0h with nothing expected", mem_req.addr);
          end else begin
            e = exp_iss.pop_front();
            check("issue_dgrant", dgrant, e.own_d);
            check("issue_igrant", igrant, !e.own_d);
            check("issue_addr", mem_req.addr, e.addr);
          end
        end
        if (iresp || dresp) begin
          if (exp_resp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: iresp %0b dresp %0b", iresp, dresp);
          end else begin
            r = exp_resp.pop_front();
            check("resp_owner_d", dresp, r);
            check("resp_owner_i", iresp, !r);
          end
        end
        if (igrant && dgrant) begin
          errors++;
          $display("FAIL both_grants: igrant 1 dgrant 1 required mutually exclusive");
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    ireq  = '0;
    dreq  = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grants", {igrant, dgrant}, 0);
    check("rst_mem_req_zero", (mem_req == '0), 1);
    check("rst_errs", {terr, serr}, 0);

    // Lone icache read, response 5 cycles after ISSUE
    lat = 5;
    push_txn(1'b0, IAddr, 1'b1);
    @(posedge clk);
    #1 ireq = '{valid: 1'b1, rw: 1'b0, addr: IAddr, data: 32'h11};
    wait_for(0, 10, "t1_issue");
    check("t1_igrant_issue", igrant, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      check("t1_igrant_held", {igrant, dgrant}, 2'b10);
    end while (!iresp && k < 20);
    check("t1_resp_latency", k, 5);
    @(posedge clk);
    #1 ireq.valid = 1'b0;
    @(negedge clk);
    check("t1_igrant_drop", {igrant, dgrant, busy}, 0);

    // Both held valid, latency 2: D,D,D,D,I,D,D,D,D,I
    lat = 2;
    for (int n = 0; n < 10; n++) begin
      if (n == 4 || n == 9) push_txn(1'b0, IAddr, 1'b1);
      else push_txn(1'b1, DAddr, 1'b1);
    end
    @(posedge clk);
    #1;
    ireq = '{valid: 1'b1, rw: 1'b0, addr: IAddr, data: 32'h0};
    dreq = '{valid: 1'b1, rw: 1'b1, addr: DAddr, data: 32'hD0};
    for (int n = 0; n < 10; n++) wait_for(3, 20, "t2_resp");
    @(posedge clk);
    #1;
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    @(negedge clk);

    // dreq arrives while icache is in WAIT: dcache ISSUE exactly 2 cycles after iresp
    lat = 5;
    push_txn(1'b0, 32'h140, 1'b1);
    push_txn(1'b1, 32'h240, 1'b1);
    @(posedge clk);
    #1 ireq = '{valid: 1'b1, rw: 1'b0, addr: 32'h140, data: 32'h0};
    wait_for(0, 10, "t3_iissue");
    @(posedge clk);
    #1 dreq = '{valid: 1'b1, rw: 1'b1, addr: 32'h240, data: 32'h55};
    wait_for(1, 20, "t3_iresp");
    check("t3_dgrant_at_iresp", dgrant, 0);
    @(posedge clk);
    #1 ireq.valid = 1'b0;
    @(negedge clk);
    check("t3_gap", {dgrant, mem_req.valid, busy}, 0);
    @(negedge clk);
    check("t3_dissue_plus2", {dgrant, mem_req.valid}, 2'b11);
    wait_for(2, 20, "t3_dresp");
    @(posedge clk);
    #1 dreq.valid = 1'b0;

    // Memory never responds: 8 WAIT cycles then IDLE with sticky timeout
    lat = -1;
    push_txn(1'b1, 32'h280, 1'b0);
    @(posedge clk);
    #1 dreq = '{valid: 1'b1, rw: 1'b1, addr: 32'h280, data: 32'hAA};
    wait_for(0, 10, "t4_issue");
    @(posedge clk);
    #1 dreq = '{valid: 1'b0, rw: 1'b0, addr: 32'h999, data: 32'h0};
    k = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!(busy && !mem_req.valid)) break;
      k++;
    end
    check("t4_wait_cycles", k, 8);
    check("t4_timeout_err", terr, 1);
    check("t4_idle_grants", {igrant, dgrant, busy}, 0);
    check("t4_fields_held", mem_req.addr, 32'h280);
    lat = 2;
    push_txn(1'b1, 32'h2C0, 1'b1);
    @(posedge clk);
    #1 dreq = '{valid: 1'b1, rw: 1'b0, addr: 32'h2C0, data: 32'h0};
    wait_for(2, 20, "t4_next_dresp");
    @(posedge clk);
    #1 dreq.valid = 1'b0;
    @(negedge clk);
    check("t4_timeout_sticky", terr, 1);

    // Spurious response in IDLE
    check("t5_serr_before", serr, 0);
    @(negedge clk);
    spur_cnt++;
    @(negedge clk);
    check("t5_grants_during", {igrant, dgrant, busy}, 0);
    @(negedge clk);
    check("t5_serr_set", serr, 1);

    // Reset in WAIT; late response arrives 2 cycles after release
    lat = 5;
    push_txn(1'b0, 32'h180, 1'b0);
    @(posedge clk);
    #1 ireq = '{valid: 1'b1, rw: 1'b0, addr: 32'h180, data: 32'h0};
    wait_for(0, 10, "t6_issue");
    @(posedge clk);
    #1;
    reset = 1'b0;
    ireq.valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_rst_busy_grants", {busy, igrant, dgrant, iresp, dresp}, 0);
    check("t6_rst_mem_req_zero", (mem_req == '0), 1);
    check("t6_rst_errs_cleared", {terr, serr}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_late_resp_in_idle", {busy, iresp, dresp}, 0);
    @(negedge clk);
    check("t6_serr_late", serr, 1);

    repeat (3) @(negedge clk);
    check("final_iss_queue_empty", exp_iss.size(), 0);
    check("final_resp_queue_empty", exp_resp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
